// File: rtl/adder_result_accum_if.sv
// Handshake/result bus between an adder stage, the batch accumulator and its consumer.
interface adder_result_accum_if #(
    parameter int unsigned IN_W  = 6,
    parameter int unsigned ACC_W = 10,
    parameter int unsigned CNT_W = 3
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_sum;
    logic              in_carry;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic [IN_W:0]     max_out;
    logic [CNT_W-1:0]  carry_cnt;
    logic              overflow;

    modport master (
        output start, in_valid, in_sum, in_carry, out_ready,
        input  in_ready, busy, out_valid, acc_out, max_out, carry_cnt, overflow
    );

    modport slave (
        input  start, in_valid, in_sum, in_carry, out_ready,
        output in_ready, busy, out_valid, acc_out, max_out, carry_cnt, overflow
    );
endinterface

// File: rtl/adder_result_accum.sv
// Accumulates NUM_SAMPLES adder results per batch into total/max/carry-count/overflow.
// Optional ADDER_ACCUM_SAT_EN: saturate the total at 2^ACC_W-1 instead of wrapping.
module adder_result_accum #(
    parameter int unsigned IN_W        = 6,
    parameter int unsigned ACC_W       = 10,
    parameter int unsigned NUM_SAMPLES = 4,
    parameter int unsigned CNT_W       = 3
) (
    input logic               clk,
    input logic               rst,
    adder_result_accum_if.slave bus
);
    localparam int unsigned OP_W  = IN_W + 1;
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [ACC_W-1:0]  acc_q;
    logic [OP_W-1:0]   max_q;
    logic [CNT_W-1:0]  carry_cnt_q;
    logic              ovf_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              out_valid_q;

    logic [OP_W-1:0]   op_c;
    logic [SUM_W-1:0]  sum_c;
    logic [ACC_W-1:0]  acc_d;
    logic [OP_W-1:0]   max_d;
    logic [CNT_W-1:0]  carry_cnt_d;
    logic              ovf_d;
    logic              beat_c;
    logic              last_c;

    // Next datapath values for an accepted beat.
    always_comb begin
        op_c        = {bus.in_carry, bus.in_sum};
        sum_c       = {1'b0, acc_q} + SUM_W'(op_c);
`ifdef ADDER_ACCUM_SAT_EN
        acc_d       = sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
`else
        acc_d       = sum_c[ACC_W-1:0];
`endif
        ovf_d       = ovf_q | sum_c[ACC_W];
        max_d       = (op_c > max_q) ? op_c : max_q;
        carry_cnt_d = carry_cnt_q + CNT_W'(bus.in_carry);
        beat_c      = bus.in_valid && in_ready_q;
        last_c      = (count_q == CNT_W'(NUM_SAMPLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            max_q       <= '0;
            carry_cnt_q <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q     <= ACCUM;
                        count_q     <= '0;
                        acc_q       <= '0;
                        max_q       <= '0;
                        carry_cnt_q <= '0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (beat_c) begin
                        acc_q       <= acc_d;
                        max_q       <= max_d;
                        carry_cnt_q <= carry_cnt_d;
                        ovf_q       <= ovf_d;
                        count_q     <= count_q + CNT_W'(1);
                        // Final beat: result is visible the cycle after it is accepted.
                        if (last_c) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_q;
    assign bus.max_out   = max_q;
    assign bus.carry_cnt = carry_cnt_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_adder_result_accum.sv
// Bench for adder_result_accum: two instances (ACC_W=10 and ACC_W=7) driven in lockstep.
module tb_adder_result_accum;
    localparam int unsigned IN_W  = 6;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned NUM   = 4;
    localparam int unsigned AW0   = 10;
    localparam int unsigned AW1   = 7;

    logic clk;
    logic rst;
    logic start;
    logic in_valid;
    logic [IN_W-1:0] in_sum;
    logic in_carry;
    logic out_ready;

    adder_result_accum_if #(.IN_W(IN_W), .ACC_W(AW0), .CNT_W(CNT_W)) b0 ();
    adder_result_accum_if #(.IN_W(IN_W), .ACC_W(AW1), .CNT_W(CNT_W)) b1 ();

    assign b0.start = start;  assign b1.start = start;
    assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;
    assign b0.in_sum = in_sum;  assign b1.in_sum = in_sum;
    assign b0.in_carry = in_carry;  assign b1.in_carry = in_carry;
    assign b0.out_ready = out_ready;  assign b1.out_ready = out_ready;

    adder_result_accum #(.IN_W(IN_W), .ACC_W(AW0), .NUM_SAMPLES(NUM), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst), .bus(b0));
    adder_result_accum #(.IN_W(IN_W), .ACC_W(AW1), .NUM_SAMPLES(NUM), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ops[$];

    logic [31:0] o_acc0, o_max0, o_cc0, o_ovf0, o_acc1, o_ovf1;
    int ov_cycles, timed_out, stable, post_ov, post_busy, idle_busy;
    logic [31:0] idle_acc0;
    int e_acc0, e_max0, e_cc0, e_ovf0, e_acc1, e_max1, e_cc1, e_ovf1;

    // Batch outcome from the rules: plain integer sum, then wrap or clamp to the width.
    function automatic void model(input int w, output int acc, output int mx,
                                  output int cc, output int ovf);
        int total;
        int lim;
        total = 0;
        lim = (1 << w) - 1;
        mx = 0;
        cc = 0;
        foreach (ops[i]) begin
            total += ops[i];
            if (ops[i] > mx) mx = ops[i];
            if (ops[i] >= 64) cc++;
        end
        ovf = (total > lim) ? 1 : 0;
`ifdef ADDER_ACCUM_SAT_EN
        acc = ovf ? lim : total;
`else
        acc = total % (1 << w);
`endif
    endfunction

    task automatic run_model();
        model(AW0, e_acc0, e_max0, e_cc0, e_ovf0);
        model(AW1, e_acc1, e_max1, e_cc1, e_ovf1);
    endtask

    // Drives one batch from ops[]; records observations only, the test tasks judge them.
    task automatic drive_batch(input int gap_max, input int bp, input bit stray);
        logic [6:0] v;
        int acc_ok;
        timed_out = 0;
        stable = 1;
        ov_cycles = 0;
        idle_busy = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < ops.size(); k++) begin
            v = 7'(ops[k]);
            in_valid = 1'b1;
            in_sum = v[5:0];
            in_carry = v[6];
            if (stray && k == 1) start = 1'b1;
            acc_ok = 0;
            for (int t = 0; t < 50 && acc_ok == 0; t++) begin
                acc_ok = (b0.in_ready === 1'b1) ? 1 : 0;
                @(posedge clk); #1;
            end
            start = 1'b0;
            in_valid = 1'b0;
            in_sum = 6'($urandom);
            in_carry = 1'($urandom);
            if (acc_ok == 0) begin
                timed_out = 1;
                return;
            end
            if (k != ops.size() - 1) begin
                repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            end
        end
        for (int t = 0; t < 20 && b0.out_valid !== 1'b1; t++) begin @(posedge clk); #1; end
        if (b0.out_valid !== 1'b1) begin
            timed_out = 1;
            return;
        end
        o_acc0 = 32'(b0.acc_out);  o_max0 = 32'(b0.max_out);
        o_cc0  = 32'(b0.carry_cnt); o_ovf0 = 32'(b0.overflow);
        o_acc1 = 32'(b1.acc_out);  o_ovf1 = 32'(b1.overflow);
        repeat (bp) begin
            if (b0.out_valid === 1'b1) ov_cycles++;
            if (32'(b0.acc_out) !== o_acc0 || 32'(b0.max_out) !== o_max0 ||
                32'(b0.carry_cnt) !== o_cc0 || 32'(b0.overflow) !== o_ovf0 ||
                b0.in_ready !== 1'b0 || b0.busy !== 1'b1 || b0.out_valid !== 1'b1)
                stable = 0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        if (stray) start = 1'b1;
        if (b0.out_valid === 1'b1) ov_cycles++;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        post_ov = (b0.out_valid === 1'b1) ? 1 : 0;
        post_busy = (b0.busy === 1'b1) ? 1 : 0;
        repeat (3) begin
            if (b0.busy !== 1'b0 || b0.out_valid !== 1'b0 || b0.in_ready !== 1'b0) idle_busy = 1;
            @(posedge clk); #1;
        end
        idle_acc0 = 32'(b0.acc_out);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", b0.in_ready); end
        checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", b0.busy); end
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", b0.out_valid); end
        checks++; if (b0.acc_out !== 10'd0 || b0.max_out !== 7'd0 || b0.carry_cnt !== 3'd0 || b0.overflow !== 1'b0) begin
            errors++; $display("FAIL reset_results: got acc=%0d max=%0d cc=%0d ovf=%b expected all 0",
                               b0.acc_out, b0.max_out, b0.carry_cnt, b0.overflow); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy: got %b expected 0", b0.busy); end
    endtask

    task automatic test_basic();
        ops = {0, 3, 7, 16};
        run_model();
        drive_batch(0, 0, 1'b0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", timed_out); end
        checks++; if (o_acc0 !== 32'(e_acc0)) begin errors++; $display("FAIL basic_acc: got %0d expected %0d", o_acc0, e_acc0); end
        checks++; if (o_max0 !== 32'(e_max0)) begin errors++; $display("FAIL basic_max: got %0d expected %0d", o_max0, e_max0); end
        checks++; if (o_cc0 !== 32'(e_cc0)) begin errors++; $display("FAIL basic_carry_cnt: got %0d expected %0d", o_cc0, e_cc0); end
        checks++; if (o_ovf0 !== 32'(e_ovf0)) begin errors++; $display("FAIL basic_overflow: got %0d expected %0d", o_ovf0, e_ovf0); end
        checks++; if (ov_cycles != 1) begin errors++; $display("FAIL basic_out_valid_cycles: got %0d expected 1", ov_cycles); end
        checks++; if (post_ov != 0 || post_busy != 0) begin errors++; $display("FAIL basic_back_to_idle: got ov=%0d busy=%0d expected 0 0", post_ov, post_busy); end
    endtask

    task automatic test_backpressure();
        ops = {0, 3, 7, 16};
        run_model();
        drive_batch(2, 5, 1'b0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL bp_timeout: got %0d expected 0", timed_out); end
        checks++; if (o_acc0 !== 32'(e_acc0) || o_max0 !== 32'(e_max0)) begin
            errors++; $display("FAIL bp_results: got acc=%0d max=%0d expected acc=%0d max=%0d", o_acc0, o_max0, e_acc0, e_max0); end
        checks++; if (stable != 1) begin errors++; $display("FAIL bp_stable_in_done: got %0d expected 1", stable); end
        checks++; if (ov_cycles != 6) begin errors++; $display("FAIL bp_out_valid_cycles: got %0d expected 6", ov_cycles); end
        checks++; if (post_ov != 0 || idle_busy != 0) begin errors++; $display("FAIL bp_back_to_idle: got ov=%0d idle_busy=%0d expected 0 0", post_ov, idle_busy); end
        checks++; if (idle_acc0 !== 32'(e_acc0)) begin errors++; $display("FAIL bp_held_in_idle: got %0d expected %0d", idle_acc0, e_acc0); end
    endtask

    task automatic test_carry();
        ops = {69, 1, 69, 1};
        run_model();
        drive_batch(1, 0, 1'b0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL carry_timeout: got %0d expected 0", timed_out); end
        checks++; if (o_acc0 !== 32'(e_acc0)) begin errors++; $display("FAIL carry_acc: got %0d expected %0d", o_acc0, e_acc0); end
        checks++; if (o_max0 !== 32'(e_max0)) begin errors++; $display("FAIL carry_max: got %0d expected %0d", o_max0, e_max0); end
        checks++; if (o_cc0 !== 32'(e_cc0)) begin errors++; $display("FAIL carry_cnt: got %0d expected %0d", o_cc0, e_cc0); end
    endtask

    task automatic test_overflow();
        ops = {64, 64, 64, 64};
        run_model();
        drive_batch(0, 0, 1'b0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL ovf_timeout: got %0d expected 0", timed_out); end
        checks++; if (o_acc1 !== 32'(e_acc1)) begin errors++; $display("FAIL ovf_acc_w7: got %0d expected %0d", o_acc1, e_acc1); end
        checks++; if (o_ovf1 !== 32'(e_ovf1)) begin errors++; $display("FAIL ovf_flag_w7: got %0d expected %0d", o_ovf1, e_ovf1); end
        checks++; if (o_acc0 !== 32'(e_acc0) || o_ovf0 !== 32'(e_ovf0)) begin
            errors++; $display("FAIL ovf_w10: got acc=%0d ovf=%0d expected acc=%0d ovf=%0d", o_acc0, o_ovf0, e_acc0, e_ovf0); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_sum = 6'd5; in_carry = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (b0.acc_out !== 10'd0 || b0.max_out !== 7'd0 || b0.carry_cnt !== 3'd0 || b0.overflow !== 1'b0) begin
            errors++; $display("FAIL midrst_results: got acc=%0d max=%0d cc=%0d ovf=%b expected all 0",
                               b0.acc_out, b0.max_out, b0.carry_cnt, b0.overflow); end
        checks++; if (b0.busy !== 1'b0 || b0.in_ready !== 1'b0 || b0.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: got busy=%b rdy=%b ov=%b expected 0 0 0", b0.busy, b0.in_ready, b0.out_valid); end
        ops = {3, 3, 3, 3};
        run_model();
        drive_batch(0, 0, 1'b0);
        checks++; if (timed_out != 0 || o_acc0 !== 32'(e_acc0)) begin
            errors++; $display("FAIL midrst_new_batch: got acc=%0d timeout=%0d expected acc=%0d timeout=0", o_acc0, timed_out, e_acc0); end
    endtask

    task automatic test_ignored_start();
        ops = {10, 70, 20, 5};
        run_model();
        drive_batch(1, 2, 1'b1);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL istart_timeout: got %0d expected 0", timed_out); end
        checks++; if (o_acc0 !== 32'(e_acc0) || o_cc0 !== 32'(e_cc0)) begin
            errors++; $display("FAIL istart_counts: got acc=%0d cc=%0d expected acc=%0d cc=%0d", o_acc0, o_cc0, e_acc0, e_cc0); end
        checks++; if (post_busy != 0 || idle_busy != 0) begin
            errors++; $display("FAIL istart_no_new_batch: got busy=%0d idle_busy=%0d expected 0 0", post_busy, idle_busy); end
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            ops.delete();
            for (int i = 0; i < int'(NUM); i++) ops.push_back(int'($urandom_range(0, 127)));
            run_model();
            drive_batch(3, int'($urandom_range(0, 3)), 1'b0);
            checks++; if (timed_out != 0) begin errors++; $display("FAIL rand%0d_timeout: got %0d expected 0", b, timed_out); end
            checks++; if (o_acc0 !== 32'(e_acc0) || o_max0 !== 32'(e_max0) || o_cc0 !== 32'(e_cc0) || o_ovf0 !== 32'(e_ovf0)) begin
                errors++; $display("FAIL rand%0d_w10: got acc=%0d max=%0d cc=%0d ovf=%0d expected %0d %0d %0d %0d",
                                   b, o_acc0, o_max0, o_cc0, o_ovf0, e_acc0, e_max0, e_cc0, e_ovf0); end
            checks++; if (o_acc1 !== 32'(e_acc1) || o_ovf1 !== 32'(e_ovf1)) begin
                errors++; $display("FAIL rand%0d_w7: got acc=%0d ovf=%0d expected %0d %0d", b, o_acc1, o_ovf1, e_acc1, e_ovf1); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_sum = '0;
        in_carry = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_carry();
        test_overflow();
        test_reset_mid();
        test_ignored_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
